// File: rtl/uart_pkg.sv
// ------------------------------------------------------------------
// uart_pkg : shared parity modes, FSM state encodings, divider helper
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START_CHK = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_BREAK     = 3'd5
  } rx_state_t;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_bit_timer.sv
// ------------------------------------------------------------------
// uart_bit_timer : loadable down-counter, ticks every DIV (or DIV/2) cycles
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module uart_bit_timer #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_half,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = $clog2(DIV) + 1;
  localparam logic [CW-1:0] c_full = CW'(DIV - 1);
  localparam logic [CW-1:0] c_half = CW'(DIV / 2 - 1);

  logic [CW-1:0] r_cnt;

  // A tick lands DIV (or DIV/2) edges after the start edge.
  assign o_tick = i_en && !i_start && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= i_half ? c_half : c_full;
    end else if (i_en) begin
      r_cnt <= (r_cnt == '0) ? c_full : r_cnt - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_core.sv
// ------------------------------------------------------------------
// uart_core : full-duplex UART with valid/ready TX and error-flagging RX
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module uart_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int IW  = $clog2(DATA_BITS + 1);
  localparam logic [IW-1:0] c_data_last = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] c_stop_last = IW'(STOP_BITS - 1);
  localparam logic c_has_par = (PARITY != PAR_NONE);
  localparam logic c_odd     = (PARITY == PAR_ODD);

  // ---------------- TX engine ----------------
  tx_state_t            r_tx_state, w_tx_state_nxt;
  logic                 r_tx, w_tx_nxt;
  logic                 r_tx_ready, w_tx_ready_nxt;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_nxt;
  logic [IW-1:0]        r_tx_idx, w_tx_idx_nxt;
  logic                 r_tx_par, w_tx_par_nxt;
  logic                 w_tx_start, w_tx_en, w_tx_tick;

  uart_bit_timer #(.DIV(DIV)) u_tx_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_tx_start),
    .i_half  (1'b0),
    .i_en    (w_tx_en),
    .o_tick  (w_tx_tick)
  );

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_nxt       = r_tx;
    w_tx_ready_nxt = r_tx_ready;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_idx_nxt   = r_tx_idx;
    w_tx_par_nxt   = r_tx_par;
    w_tx_start     = 1'b0;
    w_tx_en        = (r_tx_state != TX_IDLE);
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_nxt       = 1'b1;
        w_tx_ready_nxt = 1'b1;
        if (tx_valid && r_tx_ready) begin
          w_tx_state_nxt = TX_START;
          w_tx_shift_nxt = tx_data;
          w_tx_par_nxt   = (^tx_data) ^ c_odd;
          w_tx_ready_nxt = 1'b0;
          w_tx_nxt       = 1'b0;
          w_tx_start     = 1'b1;
        end
      end
      TX_START: begin
        if (w_tx_tick) begin
          w_tx_state_nxt = TX_DATA;
          w_tx_nxt       = r_tx_shift[0];
          w_tx_shift_nxt = r_tx_shift >> 1;
          w_tx_idx_nxt   = '0;
        end
      end
      TX_DATA: begin
        if (w_tx_tick) begin
          if (r_tx_idx == c_data_last) begin
            w_tx_idx_nxt = '0;
            if (c_has_par) begin
              w_tx_state_nxt = TX_PARITY;
              w_tx_nxt       = r_tx_par;
            end else begin
              w_tx_state_nxt = TX_STOP;
              w_tx_nxt       = 1'b1;
            end
          end else begin
            w_tx_idx_nxt   = r_tx_idx + 1'b1;
            w_tx_nxt       = r_tx_shift[0];
            w_tx_shift_nxt = r_tx_shift >> 1;
          end
        end
      end
      TX_PARITY: begin
        if (w_tx_tick) begin
          w_tx_state_nxt = TX_STOP;
          w_tx_nxt       = 1'b1;
          w_tx_idx_nxt   = '0;
        end
      end
      TX_STOP: begin
        if (w_tx_tick) begin
          if (r_tx_idx == c_stop_last) begin
            w_tx_state_nxt = TX_IDLE;
            w_tx_ready_nxt = 1'b1;
          end else begin
            w_tx_idx_nxt = r_tx_idx + 1'b1;
          end
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx       <= 1'b1;
      r_tx_ready <= 1'b0;
      r_tx_shift <= '0;
      r_tx_idx   <= '0;
      r_tx_par   <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx       <= w_tx_nxt;
      r_tx_ready <= w_tx_ready_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_idx   <= w_tx_idx_nxt;
      r_tx_par   <= w_tx_par_nxt;
    end
  end

  assign tx       = r_tx;
  assign tx_ready = r_tx_ready;

  // ---------------- RX engine ----------------
  logic [1:0]           r_sync;
  logic                 r_rx_prev;
  logic                 w_rx_s;
  rx_state_t            r_rx_state, w_rx_state_nxt;
  logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_nxt;
  logic [IW-1:0]        r_rx_idx, w_rx_idx_nxt;
  logic                 r_perr_pend, w_perr_pend_nxt;
  logic [DATA_BITS-1:0] r_rx_data, w_rx_data_nxt;
  logic                 r_rx_valid, w_rx_valid_nxt;
  logic                 r_pe, w_pe_nxt;
  logic                 r_fe, w_fe_nxt;
  logic                 w_rx_start, w_rx_half, w_rx_en, w_rx_tick;

  assign w_rx_s = r_sync[1];

  uart_bit_timer #(.DIV(DIV)) u_rx_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_rx_start),
    .i_half  (w_rx_half),
    .i_en    (w_rx_en),
    .o_tick  (w_rx_tick)
  );

  always_comb begin
    w_rx_state_nxt  = r_rx_state;
    w_rx_shift_nxt  = r_rx_shift;
    w_rx_idx_nxt    = r_rx_idx;
    w_perr_pend_nxt = r_perr_pend;
    w_rx_data_nxt   = r_rx_data;
    w_rx_valid_nxt  = 1'b0;
    w_pe_nxt        = r_pe;
    w_fe_nxt        = r_fe;
    w_rx_start      = 1'b0;
    w_rx_half       = 1'b0;
    w_rx_en         = (r_rx_state != RX_IDLE) && (r_rx_state != RX_BREAK);
    case (r_rx_state)
      RX_IDLE: begin
        if (r_rx_prev && !w_rx_s) begin
          w_rx_state_nxt  = RX_START_CHK;
          w_rx_start      = 1'b1;
          w_rx_half       = 1'b1;
          w_perr_pend_nxt = 1'b0;
        end
      end
      RX_START_CHK: begin
        // A start bit that is gone by mid-bit is treated as line noise.
        if (w_rx_tick) begin
          w_rx_state_nxt = w_rx_s ? RX_IDLE : RX_DATA;
          w_rx_idx_nxt   = '0;
        end
      end
      RX_DATA: begin
        if (w_rx_tick) begin
          w_rx_shift_nxt = {w_rx_s, r_rx_shift[DATA_BITS-1:1]};
          if (r_rx_idx == c_data_last) begin
            w_rx_state_nxt = c_has_par ? RX_PARITY : RX_STOP;
          end else begin
            w_rx_idx_nxt = r_rx_idx + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (w_rx_tick) begin
          w_perr_pend_nxt = w_rx_s ^ ((^r_rx_shift) ^ c_odd);
          w_rx_state_nxt  = RX_STOP;
        end
      end
      RX_STOP: begin
        if (w_rx_tick) begin
          w_rx_data_nxt  = r_rx_shift;
          w_rx_valid_nxt = 1'b1;
          w_pe_nxt       = r_perr_pend;
          w_fe_nxt       = !w_rx_s;
          w_rx_state_nxt = w_rx_s ? RX_IDLE : RX_BREAK;
        end
      end
      RX_BREAK: begin
        if (w_rx_s) begin
          w_rx_state_nxt = RX_IDLE;
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync      <= 2'b11;
      r_rx_prev   <= 1'b1;
      r_rx_state  <= RX_IDLE;
      r_rx_shift  <= '0;
      r_rx_idx    <= '0;
      r_perr_pend <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_pe        <= 1'b0;
      r_fe        <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], rx};
      r_rx_prev   <= w_rx_s;
      r_rx_state  <= w_rx_state_nxt;
      r_rx_shift  <= w_rx_shift_nxt;
      r_rx_idx    <= w_rx_idx_nxt;
      r_perr_pend <= w_perr_pend_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_pe        <= w_pe_nxt;
      r_fe        <= w_fe_nxt;
    end
  end

  assign rx_data       = r_rx_data;
  assign rx_valid      = r_rx_valid;
  assign rx_parity_err = r_pe;
  assign rx_frame_err  = r_fe;

endmodule

`default_nettype wire

// File: tb/tb_uart_core.sv
// ------------------------------------------------------------------
// tb_uart_core : scoreboard bench over four framing variants of uart_core
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_uart_core;

  localparam int DIV = 100;

  typedef struct {
    int         d;
    logic [8:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       tv [4];
  logic [8:0] td [4];
  logic       rx_force [4];
  logic       rx_drv [4];
  wire        tr [4];
  wire        txo [4];
  wire        rxi [4];
  wire        rv [4];
  wire        pe [4];
  wire        fe [4];
  wire [8:0]  rd [4];
  wire [7:0]  rd0, rd1, rd2;
  wire [6:0]  rd3;

  exp_t sb [$];
  int   rv_seen [4];
  int   checks;
  int   errors;

  // dut 0: 8N1, dut 1: 8E1, dut 2: 8O1, dut 3: 7N2
  for (genvar i = 0; i < 4; i++) begin : g_rx
    assign rxi[i] = rx_force[i] ? rx_drv[i] : txo[i];
  end
  assign rd[0] = {1'b0, rd0};
  assign rd[1] = {1'b0, rd1};
  assign rd[2] = {1'b0, rd2};
  assign rd[3] = {2'b0, rd3};

  uart_core #(.CLK_FREQ(100_000_000), .BAUD(1_000_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .tx_data(td[0][7:0]), .tx_valid(tv[0]), .tx_ready(tr[0]), .tx(txo[0]),
    .rx(rxi[0]), .rx_data(rd0), .rx_valid(rv[0]), .rx_parity_err(pe[0]), .rx_frame_err(fe[0]));
  uart_core #(.CLK_FREQ(100_000_000), .BAUD(1_000_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .tx_data(td[1][7:0]), .tx_valid(tv[1]), .tx_ready(tr[1]), .tx(txo[1]),
    .rx(rxi[1]), .rx_data(rd1), .rx_valid(rv[1]), .rx_parity_err(pe[1]), .rx_frame_err(fe[1]));
  uart_core #(.CLK_FREQ(100_000_000), .BAUD(1_000_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .tx_data(td[2][7:0]), .tx_valid(tv[2]), .tx_ready(tr[2]), .tx(txo[2]),
    .rx(rxi[2]), .rx_data(rd2), .rx_valid(rv[2]), .rx_parity_err(pe[2]), .rx_frame_err(fe[2]));
  uart_core #(.CLK_FREQ(100_000_000), .BAUD(1_000_000), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_d3 (
    .clk(clk), .rst_n(rst_n), .tx_data(td[3][6:0]), .tx_valid(tv[3]), .tx_ready(tr[3]), .tx(txo[3]),
    .rx(rxi[3]), .rx_data(rd3), .rx_valid(rv[3]), .rx_parity_err(pe[3]), .rx_frame_err(fe[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required end");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; outputs are sampled on the falling edge and every rx_valid pops the scoreboard.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (rv[i] === 1'b1) begin
        rv_seen[i]++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected dut%0d: got data=%0h pe=%0b fe=%0b, required no rx_valid",
                   i, rd[i], pe[i], fe[i]);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.d !== i || rd[i] !== e.data || pe[i] !== e.pe || fe[i] !== e.fe) begin
            errors++;
            $display("FAIL rx_frame dut%0d: got data=%0h pe=%0b fe=%0b, required dut%0d data=%0h pe=%0b fe=%0b",
                     i, rd[i], pe[i], fe[i], e.d, e.data, e.pe, e.fe);
          end
        end
      end
    end
  endtask

  task automatic drive_rx(input int d, input logic [15:0] bits, input int nb);
    for (int b = 0; b < nb; b++) begin
      rx_drv[d] = bits[b];
      repeat (DIV) step();
    end
  endtask

  // Sends one frame via the handshake, checks every tx cycle, tx_ready low for L cycles, and loopback rx.
  task automatic send_check(input int d, input logic [8:0] data, input int nbits,
                            input int has_par, input logic par_val, input int nstop);
    logic [15:0] bits;
    int nb, len, bad;
    bits = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < nbits; i++) bits[1 + i] = data[i];
    nb = 1 + nbits;
    if (has_par != 0) begin
      bits[nb] = par_val;
      nb++;
    end
    for (int i = 0; i < nstop; i++) begin
      bits[nb] = 1'b1;
      nb++;
    end
    len = DIV * nb;
    sb.push_back('{d: d, data: data, pe: 1'b0, fe: 1'b0});
    td[d] = data;
    tv[d] = 1'b1;
    bad = 0;
    for (int k = 1; k <= len; k++) begin
      step();
      if (k == 1) tv[d] = 1'b0;
      if (txo[d] !== bits[(k - 1) / DIV] || tr[d] !== 1'b0) bad++;
      if (k % DIV == 0) begin
        checks++;
        if (bad != 0) begin
          errors++;
          $display("FAIL tx_bit dut%0d bit%0d: got tx=%0b ready=%0b in %0d cycles, required tx=%0b ready=0",
                   d, (k - 1) / DIV, txo[d], tr[d], bad, bits[(k - 1) / DIV]);
        end
        bad = 0;
      end
    end
    step();
    checks++;
    if (tr[d] !== 1'b1) begin
      errors++;
      $display("FAIL tx_ready_rise dut%0d: got %0b at %0d cycles after handshake, required 1", d, tr[d], len);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rx_loopback dut%0d: got %0d frames pending, required 0", d, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tv[i] = 1'b0; td[i] = '0; rx_force[i] = 1'b0; rx_drv[i] = 1'b1; rv_seen[i] = 0;
    end
    repeat (5) step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (txo[i] !== 1'b1) begin
        errors++; $display("FAIL reset_tx dut%0d: got %0b, required 1", i, txo[i]);
      end
      checks++;
      if (tr[i] !== 1'b0) begin
        errors++; $display("FAIL reset_ready dut%0d: got %0b, required 0", i, tr[i]);
      end
      checks++;
      if ({rd[i], rv[i], pe[i], fe[i]} !== 12'h000) begin
        errors++; $display("FAIL reset_rx dut%0d: got data=%0h v=%0b pe=%0b fe=%0b, required all 0",
                           i, rd[i], rv[i], pe[i], fe[i]);
      end
    end
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tr[i] !== 1'b1) begin
        errors++; $display("FAIL reset_ready_rise dut%0d: got %0b, required 1", i, tr[i]);
      end
    end
  endtask

  task automatic test_8n1();
    int c0;
    c0 = rv_seen[0];
    send_check(0, 9'h41, 8, 0, 1'b0, 1);
    repeat (20) step();
    checks++;
    if (rv_seen[0] - c0 != 1) begin
      errors++; $display("FAIL 8n1_rx_pulses: got %0d, required 1", rv_seen[0] - c0);
    end
  endtask

  task automatic test_parity();
    logic [15:0] b;
    send_check(1, 9'h41, 8, 1, 1'b0, 1);
    send_check(2, 9'h41, 8, 1, 1'b1, 1);
    // even-parity receiver fed 0x41 with the parity bit inverted
    rx_drv[1] = 1'b1;
    rx_force[1] = 1'b1;
    repeat (10) step();
    sb.push_back('{d: 1, data: 9'h41, pe: 1'b1, fe: 1'b0});
    b = {5'b0, 1'b1, 1'b1, 8'h41, 1'b0};
    drive_rx(1, b, 11);
    repeat (20) step();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL parity_inject: got %0d frames pending, required 0", sb.size());
    end
    rx_force[1] = 1'b0;
  endtask

  task automatic test_glitch();
    logic [15:0] b;
    int c0;
    c0 = rv_seen[0];
    rx_drv[0] = 1'b1;
    rx_force[0] = 1'b1;
    repeat (10) step();
    rx_drv[0] = 1'b0;
    repeat (30) step();
    rx_drv[0] = 1'b1;
    repeat (40) step();
    checks++;
    if (rv_seen[0] != c0) begin
      errors++; $display("FAIL glitch_reject: got %0d rx_valid, required 0", rv_seen[0] - c0);
    end
    sb.push_back('{d: 0, data: 9'h5A, pe: 1'b0, fe: 1'b0});
    b = {6'b0, 1'b1, 8'h5A, 1'b0};
    drive_rx(0, b, 10);
    repeat (20) step();
    checks++;
    if (sb.size() != 0 || rv_seen[0] - c0 != 1) begin
      errors++; $display("FAIL glitch_next_frame: got %0d pending, %0d pulses, required 0 pending, 1 pulse",
                         sb.size(), rv_seen[0] - c0);
    end
    rx_force[0] = 1'b0;
  endtask

  task automatic test_break();
    logic [15:0] b;
    int c0;
    c0 = rv_seen[0];
    rx_drv[0] = 1'b1;
    rx_force[0] = 1'b1;
    repeat (10) step();
    sb.push_back('{d: 0, data: 9'hFF, pe: 1'b0, fe: 1'b1});
    b = {6'b0, 1'b0, 8'hFF, 1'b0};
    drive_rx(0, b, 10);
    repeat (500) step();
    rx_drv[0] = 1'b1;
    repeat (300) step();
    checks++;
    if (sb.size() != 0 || rv_seen[0] - c0 != 1) begin
      errors++; $display("FAIL break_frame_err: got %0d pending, %0d pulses, required 0 pending, 1 pulse",
                         sb.size(), rv_seen[0] - c0);
    end
    rx_force[0] = 1'b0;
    repeat (10) step();
    send_check(0, 9'h3C, 8, 0, 1'b0, 1);
  endtask

  task automatic test_back_to_back();
    int k;
    sb.push_back('{d: 0, data: 9'h00, pe: 1'b0, fe: 1'b0});
    sb.push_back('{d: 0, data: 9'h55, pe: 1'b0, fe: 1'b0});
    td[0] = 9'h00;
    tv[0] = 1'b1;
    step();
    td[0] = 9'h55;
    k = 1;
    while (tr[0] !== 1'b1 && k < 3000) begin
      step();
      k++;
    end
    checks++;
    if (k != 1001 || txo[0] !== 1'b1) begin
      errors++; $display("FAIL b2b_first_len: got ready at %0d tx=%0b, required 1001 tx=1", k, txo[0]);
    end
    step();
    tv[0] = 1'b0;
    checks++;
    if (txo[0] !== 1'b0 || tr[0] !== 1'b0) begin
      errors++; $display("FAIL b2b_gap: got tx=%0b ready=%0b, required tx=0 ready=0", txo[0], tr[0]);
    end
    k = 1;
    while (tr[0] !== 1'b1 && k < 3000) begin
      step();
      k++;
    end
    checks++;
    if (k != 1001) begin
      errors++; $display("FAIL b2b_second_len: got ready at %0d, required 1001", k);
    end
    repeat (10) step();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL b2b_rx: got %0d frames pending, required 0", sb.size());
    end
  endtask

  task automatic test_7n2();
    send_check(3, 9'h2B, 7, 0, 1'b0, 2);
  endtask

  task automatic test_reset_mid();
    int c0;
    c0 = rv_seen[0];
    td[0] = 9'hA5;
    tv[0] = 1'b1;
    step();
    tv[0] = 1'b0;
    repeat (449) step();
    rst_n = 1'b0;
    step();
    checks++;
    if (txo[0] !== 1'b1 || tr[0] !== 1'b0) begin
      errors++; $display("FAIL reset_mid_tx: got tx=%0b ready=%0b, required tx=1 ready=0", txo[0], tr[0]);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (tr[0] !== 1'b1) begin
      errors++; $display("FAIL reset_mid_ready: got %0b, required 1", tr[0]);
    end
    repeat (1200) step();
    checks++;
    if (rv_seen[0] != c0) begin
      errors++; $display("FAIL reset_mid_rx: got %0d rx_valid, required 0", rv_seen[0] - c0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_8n1();
    test_parity();
    test_glitch();
    test_break();
    test_back_to_back();
    test_7n2();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d frames pending, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_core.md
Name: uart_core

Overview:
- Full-duplex UART with independent TX and RX engines, parametrised in clock/baud, data width, parity mode and stop-bit count.
- Successor to the fixed 8N1 transmitter/receiver. Adds a valid/ready TX handshake, a metastability synchroniser, mid-bit RX sampling, start-glitch rejection, and parity/framing error reporting.
- Sits between a byte-stream producer/consumer and the board-level serial pins.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate. DIV = CLK_FREQ/BAUD, integer-truncated; clock cycles per bit; must be >= 16.
- DATA_BITS, 8, payload bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits transmitted: 1 or 2. RX always checks only the first stop bit.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- tx_data  in  DATA_BITS  payload to send; sampled on handshake.
- tx_valid  in  1  producer has data.
- tx_ready  out  1  TX engine idle and able to accept.
- tx  out  1  serial output; idle high.
- rx  in  1  serial input; asynchronous to clk.
- rx_data  out  DATA_BITS  last received payload; held until the next frame completes.
- rx_valid  out  1  one-cycle pulse when rx_data/errors update.
- rx_parity_err  out  1  parity mismatch for the frame flagged by rx_valid.
- rx_frame_err  out  1  first stop bit sampled low for the frame flagged by rx_valid.

Behaviour:
- Reset (rst_n low at a clk edge):
  - Output values: tx=1, tx_ready=0, rx_data=0, rx_valid=0, both errors 0.
  - Both engines go to IDLE, bit timers clear, synchroniser flops set to 1.
  - tx_ready rises on the first edge with rst_n high.
  - Reset mid-frame aborts immediately: tx returns high the next cycle and any partial RX frame is discarded with no rx_valid.
- TX handshake:
  - Transfer occurs on an edge where tx_valid && tx_ready. tx_data is latched and tx_ready drops on that edge.
  - tx_valid without tx_ready is ignored, not queued.
- TX states: IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP -> IDLE.
  - tx drives 0 from the cycle after the handshake.
  - Each bit is held exactly DIV cycles. Data is sent LSB first.
  - Parity bit: even mode = XOR of data bits; odd mode = its inverse.
  - STOP holds tx=1 for STOP_BITS*DIV cycles.
  - Frame length L = DIV*(1+DATA_BITS+(PARITY!=0)+STOP_BITS). tx_ready is asserted again exactly L cycles after the handshake edge.
  - Back-to-back: if tx_valid is held high, the next start bit begins the cycle after tx_ready rises, so the gap is 1 cycle.
- RX synchroniser: rx passes through 2 flops (rx_s); all RX decisions use rx_s.
- RX states: IDLE -> START_CHK -> DATA -> PARITY (skipped when none) -> STOP -> IDLE; plus BREAK.
  - IDLE: a 1->0 transition on rx_s enters START_CHK.
  - START_CHK: after DIV/2 cycles, sample rx_s. If 1, treat as a glitch and return to IDLE with no flags. If 0, enter DATA.
  - DATA: sample every DIV cycles (mid-bit) and shift in LSB first.
  - PARITY: compare the sampled bit with the computed parity.
  - STOP: sample at mid-bit. On the same edge load rx_data, the error flags and rx_valid=1 (one cycle).
  - After STOP: if the stop sample was 1, go to IDLE immediately; the next falling edge is accepted right away. If the stop sample was 0 (frame error), go to BREAK and remain until rx_s=1, then IDLE.
- RX has no backpressure; the consumer must capture on rx_valid. A new frame overwrites rx_data.
- rx_parity_err is 0 when PARITY=0. Error flags are valid only in the rx_valid cycle and are cleared when the next rx_valid fires.
- TX and RX are fully independent; simultaneous activity is allowed.
- Timer arithmetic: counters are $clog2(DIV)+1 bits wide. Bit index is $clog2(DATA_BITS+1) bits wide. No wrap is reachable in legal configurations.

Decomposition:
- uart_pkg:
  - Parity mode constants (PAR_NONE, PAR_ODD, PAR_EVEN).
  - TX state enum and RX state enum.
  - Function calc_div(clk_freq, baud).
- One sub-module, uart_bit_timer, instantiated once per engine:
  - Loadable down-counter.
  - Inputs: clk, rst_n, start, half (load DIV/2 vs DIV).
  - Output: tick pulse on expiry; auto-reloads DIV while enabled.
- TX/RX FSMs, synchroniser and parity logic stay in uart_core.

Test Plan:
All scenarios use CLK_FREQ=100_000_000, BAUD=1_000_000 (DIV=100), with tx looped to rx unless stated.
- 8N1, send 0x41: tx is 0 for 100 cycles, then bits 1,0,0,0,0,0,1,0 at 100 cycles each, then 1. tx_ready is low exactly 1000 cycles. rx_valid pulses once with rx_data=0x41 and both errors 0.
- PARITY=2 sends 0x41 with parity bit 0; PARITY=1 sends it with parity bit 1. Injecting a flipped parity bit on rx gives rx_valid with rx_parity_err=1 and rx_data=0x41.
- rx driven low for 30 cycles, then high: no rx_valid, and a valid 0x5A frame sent immediately after is received correctly.
- Stop bit forced low on 0xFF: rx_valid with rx_frame_err=1 and rx_data=0xFF. rx then held low 500 cycles and raised: no extra rx_valid, and the next frame decodes.
- tx_valid held high with 0x00 then 0x55: second start bit begins 1 cycle after tx_ready rises. DATA_BITS=7, STOP_BITS=2: frame length is 1000 cycles.
- rst_n pulsed low mid-TX (bit 3) and mid-RX: tx=1 on the next cycle, tx_ready=1 the cycle after rst_n rises, and no rx_valid for the aborted frame.
